sync_fifo_prog: RTL and testbench
=================================

# sync_fifo_prog

Single-clock, parametrised FIFO that succeeds the team's dual-pointer CDC FIFO for same-domain buffering. It uses all DEPTH entries, reports an exact fill count, programmable almost-full/almost-empty flags and sticky overflow/underflow errors. A mode parameter selects first-word-fall-through or registered-read output. It sits between same-clock producer/consumer stages wherever rate smoothing or backpressure is needed.

## Interface
- DATA_WIDTH, 8, payload width in bits (≥1)
- DEPTH, 16, entry count; power of two, ≥2
- ADDR_WIDTH, $clog2(DEPTH), memory index width
- ALMOST_FULL_LEVEL, DEPTH-2, o_Almost_Full asserts at count ≥ this (1..DEPTH)
- ALMOST_EMPTY_LEVEL, 2, o_Almost_Empty asserts at count ≤ this (0..DEPTH-1)
- FWFT, 1, 1 = first-word-fall-through, 0 = registered read
- i_Clock  in  1  single clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- i_Input_Data  in  DATA_WIDTH  write payload
- i_Write_Enable  in  1  write request
- i_Read_Enable  in  1  read request (FWFT: pop head; mode 0: fetch head)
- i_Clear_Errors  in  1  clears o_Overflow/o_Underflow
- o_Output_Data  out  DATA_WIDTH  read payload
- o_Valid  out  1  o_Output_Data is meaningful
- o_Empty  out  1  count == 0
- o_Full  out  1  count == DEPTH
- o_Almost_Full  out  1  count ≥ ALMOST_FULL_LEVEL
- o_Almost_Empty  out  1  count ≤ ALMOST_EMPTY_LEVEL
- o_Count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- o_Overflow  out  1  sticky: write attempted while full
- o_Underflow  out  1  sticky: read attempted while empty

## Operation
- Write accepted = i_Write_Enable && !o_Full; read accepted = i_Read_Enable && !o_Empty; both use pre-edge flags.
- Pointers are ADDR_WIDTH bits, wrap DEPTH-1 → 0 naturally; occupancy held in a count register (no slot wasted).
- Count next = count + wr_acc − rd_acc; both accepted → unchanged.
- Full + write + read: read accepted, write rejected, count → DEPTH-1, o_Overflow set.
- Empty + write + read: write accepted, read rejected, count → 1, o_Underflow set.
- Flags are combinational decodes of the count register (no extra latency).
- Errors: set on the edge after a rejected request; hold until i_Clear_Errors. Same-cycle set and clear → set wins.
- FWFT=1: o_Output_Data = mem[rd_ptr] combinationally, o_Valid = !o_Empty; value unspecified when o_Valid=0.
- FWFT=0: accepted read registers mem[rd_ptr] into o_Output_Data on that edge; o_Valid high for exactly the following cycle; data register holds its value otherwise.
- Write and read of the same entry in one cycle (count=0 not possible as read rejected; count=DEPTH not possible as write rejected) → no read-during-write hazard.
- Reset values: o_Count 0, o_Empty 1, o_Full 0, o_Almost_Empty 1, o_Almost_Full 0, o_Overflow 0, o_Underflow 0, o_Valid 0, o_Output_Data 0 (FWFT=0). Memory contents not cleared.
- Reset mid-operation: all requests in that cycle discarded; pointers and count zeroed on that edge; stale entries never visible.

## Timing
- Write → visible: FWFT=1 head valid 1 cycle after the write edge; FWFT=0 earliest o_Valid 2 cycles after write (write edge, read edge).
- Flag/count update: same edge as the accepted transfer.
- Sustained throughput: 1 write and 1 read per cycle at any occupancy 1..DEPTH-1.
- No combinational path from inputs to outputs except i_Read_Enable-independent FWFT data (memory read port).

## Test plan
- Reset then idle: o_Count=0, o_Empty=1, o_Almost_Empty=1, all others 0; holds for 10 cycles.
- DEPTH=16, write 0x00..0x0F back-to-back: o_Full=1 at count 16, o_Almost_Full from count 14; 17th write → o_Overflow=1, count stays 16; drain reads 0x00..0x0F in order, then o_Empty=1.
- At full, assert write (0xAA) and read together: count → 15, o_Overflow=1, 0xAA never read out.
- At empty, assert write (0x55) and read together: count → 1, o_Underflow=1; next read returns 0x55.
- FWFT=0 build: write 0x3C, read next cycle → o_Valid=1 with 0x3C one cycle later for one cycle only; continuous read/write 100 cycles at count 8 → count constant, data in order across pointer wrap.
- Fill to 5, pulse resetn low one cycle with write active: count=0, o_Empty=1, errors 0; subsequent write/read returns only new data; i_Clear_Errors concurrent with overflow keeps o_Overflow=1.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO using all DEPTH entries, with an exact fill count,
// programmable almost flags, sticky errors and FWFT or registered-read output.
module sync_fifo_prog #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned DEPTH              = 16,
  parameter int unsigned ADDR_WIDTH         = $clog2(DEPTH),
  parameter int unsigned ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 2,
  parameter int unsigned FWFT               = 1
) (
  input  logic                  i_Clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] i_Input_Data,
  input  logic                  i_Write_Enable,
  input  logic                  i_Read_Enable,
  input  logic                  i_Clear_Errors,
  output logic [DATA_WIDTH-1:0] o_Output_Data,
  output logic                  o_Valid,
  output logic                  o_Empty,
  output logic                  o_Full,
  output logic                  o_Almost_Full,
  output logic                  o_Almost_Empty,
  output logic [ADDR_WIDTH:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Underflow
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode straight from the count register
  assign o_Count        = count;
  assign o_Empty        = (count == '0);
  assign o_Full         = (count == DEPTH_C);
  assign o_Almost_Full  = (count >= AF_C);
  assign o_Almost_Empty = (count <= AE_C);

  assign wr_acc = i_Write_Enable && !o_Full;
  assign rd_acc = i_Read_Enable && !o_Empty;

  // Storage is never reset; the reset gate keeps a discarded write out of memory
  always_ff @(posedge i_Clock) begin
    if (resetn && wr_acc) begin
      mem[wr_ptr] <= i_Input_Data;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors: a new rejected request takes priority over a clear
  always_ff @(posedge i_Clock) begin
    if (!resetn) begin
      o_Overflow  <= 1'b0;
      o_Underflow <= 1'b0;
    end else begin
      if (i_Write_Enable && o_Full)      o_Overflow <= 1'b1;
      else if (i_Clear_Errors)           o_Overflow <= 1'b0;
      if (i_Read_Enable && o_Empty)      o_Underflow <= 1'b1;
      else if (i_Clear_Errors)           o_Underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_Output_Data = mem[rd_ptr];
      assign o_Valid       = !o_Empty;
    end else begin : g_reg
      // Accepted read captures the head; valid pulses for the following cycle
      always_ff @(posedge i_Clock) begin
        if (!resetn) begin
          o_Output_Data <= '0;
          o_Valid       <= 1'b0;
        end else begin
          o_Valid <= rd_acc;
          if (rd_acc) o_Output_Data <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: one FWFT instance and one registered-read
// instance sharing a clock, each scenario in its own task.
`timescale 1ns/1ps
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // FWFT instance
  logic       f_resetn, f_we, f_re, f_clr;
  logic [7:0] f_din, f_dout;
  logic       f_valid, f_empty, f_full, f_af, f_ae, f_ov, f_un;
  logic [4:0] f_count;

  // Registered-read instance
  logic       r_resetn, r_we, r_re, r_clr;
  logic [7:0] r_din, r_dout;
  logic       r_valid, r_empty, r_full, r_af, r_ae, r_ov, r_un;
  logic [4:0] r_count;

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) dut_fwft (
    .i_Clock(clk), .resetn(f_resetn), .i_Input_Data(f_din),
    .i_Write_Enable(f_we), .i_Read_Enable(f_re), .i_Clear_Errors(f_clr),
    .o_Output_Data(f_dout), .o_Valid(f_valid), .o_Empty(f_empty),
    .o_Full(f_full), .o_Almost_Full(f_af), .o_Almost_Empty(f_ae),
    .o_Count(f_count), .o_Overflow(f_ov), .o_Underflow(f_un)
  );

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) dut_reg (
    .i_Clock(clk), .resetn(r_resetn), .i_Input_Data(r_din),
    .i_Write_Enable(r_we), .i_Read_Enable(r_re), .i_Clear_Errors(r_clr),
    .o_Output_Data(r_dout), .o_Valid(r_valid), .o_Empty(r_empty),
    .o_Full(r_full), .o_Almost_Full(r_af), .o_Almost_Empty(r_ae),
    .o_Count(r_count), .o_Overflow(r_ov), .o_Underflow(r_un)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic f_push(input logic [7:0] d);
    f_we = 1'b1; f_din = d;
    tick();
    f_we = 1'b0;
  endtask

  task automatic f_clear();
    f_clr = 1'b1;
    tick();
    f_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] st;
    f_resetn = 1'b0; r_resetn = 1'b0;
    f_we = 0; f_re = 0; f_clr = 0; f_din = 0;
    r_we = 0; r_re = 0; r_clr = 0; r_din = 0;
    tick(); tick();
    f_resetn = 1'b1; r_resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      st = {f_count, f_empty, f_full, f_ae, f_af, f_ov, f_un, f_valid};
      total++;
      if (st !== 12'b00000_1_0_1_0_0_0_0)
        $display("FAIL reset_fwft cycle %0d: got %b want %b", c, st, 12'b00000_1_0_1_0_0_0_0);
      else passed++;
      st = {r_count, r_empty, r_full, r_ae, r_af, r_ov, r_un, r_valid};
      total++;
      if (st !== 12'b00000_1_0_1_0_0_0_0 || r_dout !== 8'h00)
        $display("FAIL reset_reg cycle %0d: got %b/%h want %b/00", c, st, r_dout, 12'b00000_1_0_1_0_0_0_0);
      else passed++;
      tick();
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      f_push(8'(i));
      total++;
      if ({f_count, f_full, f_af} !== {5'(i + 1), (i == 15), (i + 1 >= 14)})
        $display("FAIL fill_flags n=%0d: count=%0d full=%b af=%b want count=%0d full=%b af=%b",
                 i + 1, f_count, f_full, f_af, i + 1, (i == 15), (i + 1 >= 14));
      else passed++;
    end
    f_push(8'hFF);
    total++;
    if (f_ov !== 1'b1 || f_count !== 5'd16)
      $display("FAIL overflow_17th: ov=%b count=%0d want ov=1 count=16", f_ov, f_count);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({f_valid, f_dout} !== {1'b1, 8'(i)})
        $display("FAIL drain_data idx=%0d: valid=%b data=%h want 1/%h", i, f_valid, f_dout, 8'(i));
      else passed++;
      f_re = 1'b1;
      tick();
      f_re = 1'b0;
      total++;
      if (f_ae !== (15 - i <= 2))
        $display("FAIL drain_ae count=%0d: ae=%b want %b", 15 - i, f_ae, (15 - i <= 2));
      else passed++;
    end
    total++;
    if ({f_empty, f_valid, f_count} !== {1'b1, 1'b0, 5'd0})
      $display("FAIL drain_empty: empty=%b valid=%b count=%0d want 1/0/0", f_empty, f_valid, f_count);
    else passed++;
    f_clear();
    total++;
    if (f_ov !== 1'b0) $display("FAIL clear_overflow: ov=%b want 0", f_ov);
    else passed++;
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) f_push(8'h10 + 8'(i));
    f_we = 1'b1; f_re = 1'b1; f_din = 8'hAA;
    tick();
    f_we = 1'b0; f_re = 1'b0;
    total++;
    if (f_count !== 5'd15 || f_ov !== 1'b1)
      $display("FAIL full_rw: count=%0d ov=%b want 15/1", f_count, f_ov);
    else passed++;
    for (int i = 1; i < 16; i++) begin
      total++;
      if (f_dout !== 8'h10 + 8'(i))
        $display("FAIL full_rw_order idx=%0d: data=%h want %h", i, f_dout, 8'h10 + 8'(i));
      else passed++;
      f_re = 1'b1;
      tick();
      f_re = 1'b0;
    end
    total++;
    if (f_empty !== 1'b1) $display("FAIL full_rw_empty: empty=%b want 1", f_empty);
    else passed++;
    f_clear();
  endtask

  task automatic test_empty_rw();
    f_we = 1'b1; f_re = 1'b1; f_din = 8'h55;
    tick();
    f_we = 1'b0; f_re = 1'b0;
    total++;
    if ({f_count, f_un, f_valid, f_dout} !== {5'd1, 1'b1, 1'b1, 8'h55})
      $display("FAIL empty_rw: count=%0d un=%b valid=%b data=%h want 1/1/1/55",
               f_count, f_un, f_valid, f_dout);
    else passed++;
    f_re = 1'b1;
    tick();
    f_re = 1'b0;
    total++;
    if (f_empty !== 1'b1) $display("FAIL empty_rw_pop: empty=%b want 1", f_empty);
    else passed++;
    f_clear();
    total++;
    if (f_un !== 1'b0) $display("FAIL clear_underflow: un=%b want 0", f_un);
    else passed++;
  endtask

  task automatic test_reg_mode();
    logic [7:0] wval;
    logic [7:0] rexp;
    r_we = 1'b1; r_din = 8'h3C;
    tick();
    r_we = 1'b0;
    total++;
    if (r_valid !== 1'b0) $display("FAIL reg_early_valid: valid=%b want 0", r_valid);
    else passed++;
    r_re = 1'b1;
    tick();
    r_re = 1'b0;
    total++;
    if ({r_valid, r_dout} !== {1'b1, 8'h3C})
      $display("FAIL reg_read: valid=%b data=%h want 1/3c", r_valid, r_dout);
    else passed++;
    tick();
    total++;
    if ({r_valid, r_dout} !== {1'b0, 8'h3C})
      $display("FAIL reg_pulse: valid=%b data=%h want 0/3c", r_valid, r_dout);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      r_we = 1'b1; r_din = 8'(i);
      tick();
    end
    r_we = 1'b0;
    wval = 8'd8;
    rexp = 8'd0;
    for (int c = 0; c < 100; c++) begin
      r_we = 1'b1; r_re = 1'b1; r_din = wval;
      tick();
      total++;
      if ({r_count, r_valid, r_dout} !== {5'd8, 1'b1, rexp})
        $display("FAIL reg_stream cycle %0d: count=%0d valid=%b data=%h want 8/1/%h",
                 c, r_count, r_valid, r_dout, rexp);
      else passed++;
      wval = wval + 8'd1;
      rexp = rexp + 8'd1;
    end
    r_we = 1'b0; r_re = 1'b0;
    tick();
    total++;
    if (r_valid !== 1'b0) $display("FAIL reg_stream_stop: valid=%b want 0", r_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    f_re = 1'b1;
    tick();
    f_re = 1'b0;
    total++;
    if (f_un !== 1'b1) $display("FAIL mid_underflow_set: un=%b want 1", f_un);
    else passed++;
    for (int i = 0; i < 5; i++) f_push(8'h60 + 8'(i));
    f_resetn = 1'b0; f_we = 1'b1; f_din = 8'h99;
    tick();
    f_resetn = 1'b1; f_we = 1'b0;
    total++;
    if ({f_count, f_empty, f_ov, f_un, f_valid} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL mid_reset: count=%0d empty=%b ov=%b un=%b valid=%b want 0/1/0/0/0",
               f_count, f_empty, f_ov, f_un, f_valid);
    else passed++;
    f_push(8'h77);
    f_push(8'h78);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({f_count, f_dout} !== {5'(2 - i), 8'h77 + 8'(i)})
        $display("FAIL mid_newdata idx=%0d: count=%0d data=%h want %0d/%h",
                 i, f_count, f_dout, 2 - i, 8'h77 + 8'(i));
      else passed++;
      f_re = 1'b1;
      tick();
      f_re = 1'b0;
    end
    total++;
    if (f_empty !== 1'b1) $display("FAIL mid_empty: empty=%b want 1", f_empty);
    else passed++;
    for (int i = 0; i < 16; i++) f_push(8'(i));
    f_we = 1'b1; f_clr = 1'b1; f_din = 8'hEE;
    tick();
    f_we = 1'b0; f_clr = 1'b0;
    total++;
    if (f_ov !== 1'b1) $display("FAIL set_beats_clear: ov=%b want 1", f_ov);
    else passed++;
    f_clear();
    total++;
    if (f_ov !== 1'b0 || f_count !== 5'd16)
      $display("FAIL clear_after: ov=%b count=%0d want 0/16", f_ov, f_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_reg_mode();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
